ucaspian_axon: RTL

UCASPIAN_AXON -- requirements
Module: ucaspian_axon

---
 rtl/ucaspian_axon.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ucaspian_axon.sv
// ucaspian_axon
// Axon fan-out stage. Each fired neuron index from the neuron stage is looked
// up in a 256-entry axon table. The entry holds a base synapse address and a
// synapse count. The block then emits that many consecutive synapse
// addresses, wrapping modulo 2^SYN_AW, on a valid/ready stream.
//
// Ports:
//   clk           single clock, all state updates on the rising edge
//   reset         asynchronous active-low reset (0 = in reset)
//   enable        permits acceptance of new fires
//   clear_act     abort all activity while held
//   clear_config  abort all activity and zero the whole axon table while held
//   clear_done    clear operation finished (held while clear stays asserted)
//   config_*      table programming: byte 1/2 latch start, byte 3 commits entry
//   step_done     registered idle indication
//   axon_*        fired-neuron input stream (valid/ready)
//   synapse_*     synapse-index output stream (valid/ready)
module ucaspian_axon #(
    parameter int SYN_AW  = 12,
    parameter int NEURONS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear_act,
    input  logic              clear_config,
    output logic              clear_done,
    input  logic [7:0]        config_addr,
    input  logic [11:0]       config_value,
    input  logic [2:0]        config_byte,
    input  logic              config_enable,
    output logic              step_done,
    input  logic [7:0]        axon_addr,
    input  logic              axon_vld,
    output logic              axon_rdy,
    output logic [SYN_AW-1:0] synapse_addr,
    output logic              synapse_vld,
    input  logic              synapse_rdy
);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        EMIT,
        CLEAR
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [19:0] axon_table [NEURONS];
    logic [19:0] rd_data;
    logic        tbl_we;
    logic [7:0]  tbl_waddr;
    logic [19:0] tbl_wdata;

    logic [11:0] start_latch;
    logic [7:0]  remaining;
    logic [7:0]  clr_cnt;
    logic        clr_finished;

    logic        clear_any;
    logic        fire;
    logic        beat;
    logic        unused_cfg_bits;

    assign clear_any       = clear_act || clear_config;
    assign beat            = synapse_vld && synapse_rdy;
    assign unused_cfg_bits = ^config_value[11:8];

    // A fire is only taken in IDLE while enabled, out of reset, and with no
    // clear or configuration access competing for the table port.
    assign axon_rdy = (state == IDLE) && enable && reset && !clear_any && !config_enable;
    assign fire     = axon_vld && axon_rdy;

    // The table is plain storage with no reset, so its contents are undefined
    // until a clear_config sweep. The read is registered only on an accepted
    // fire, which makes the entry available during the LOOKUP cycle.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            axon_table[tbl_waddr] <= tbl_wdata;
        end
        if (fire) begin
            rd_data <= axon_table[axon_addr];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the single table write port. Writes come either
    // from a config commit in IDLE or from the clear_config zeroing sweep.
    // A clear request preempts every other state.
    always_comb begin
        next_state = state;
        tbl_we     = 1'b0;
        tbl_waddr  = config_addr;
        tbl_wdata  = '0;
        case (state)
            IDLE: begin
                if (clear_any) begin
                    next_state = CLEAR;
                end else if (config_enable) begin
                    if (config_byte == 3'd3) begin
                        tbl_we    = 1'b1;
                        tbl_wdata = {config_value[7:0], start_latch};
                    end
                end else if (fire) begin
                    next_state = LOOKUP;
                end
            end
            LOOKUP: begin
                if (clear_any) begin
                    next_state = CLEAR;
                end else if (rd_data[19:12] == 8'd0) begin
                    next_state = IDLE;
                end else begin
                    next_state = EMIT;
                end
            end
            EMIT: begin
                if (clear_any) begin
                    next_state = CLEAR;
                end else if (beat && remaining == 8'd1) begin
                    next_state = IDLE;
                end
            end
            CLEAR: begin
                if (!clear_any) begin
                    next_state = IDLE;
                end else if (clear_config && !clr_finished) begin
                    tbl_we    = 1'b1;
                    tbl_waddr = clr_cnt;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath registers. A clear drops the output stream at once and then
    // tracks the zeroing sweep. clear_done rises the cycle after the last
    // write, or after the first CLEAR cycle when only activity is aborted.
    // Without a clear, the state decides whether config bytes are latched,
    // a table entry is loaded, or the emission advances by one beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            synapse_vld  <= 1'b0;
            synapse_addr <= '0;
            remaining    <= '0;
            start_latch  <= '0;
            clr_cnt      <= '0;
            clr_finished <= 1'b0;
            clear_done   <= 1'b0;
            step_done    <= 1'b0;
        end else begin
            step_done <= (state == IDLE) && !axon_vld && !synapse_vld && !clear_any;
            if (clear_any) begin
                synapse_vld <= 1'b0;
                if (state == CLEAR) begin
                    if (tbl_we) begin
                        clr_cnt <= clr_cnt + 8'd1;
                        if (clr_cnt == 8'hFF) begin
                            clr_finished <= 1'b1;
                        end
                    end
                    clear_done <= clear_config ?
                                  (clr_finished || (tbl_we && clr_cnt == 8'hFF)) : 1'b1;
                end
            end else begin
                clear_done   <= 1'b0;
                clr_cnt      <= '0;
                clr_finished <= 1'b0;
                case (state)
                    IDLE: begin
                        if (config_enable && config_byte == 3'd1) begin
                            start_latch[7:0] <= config_value[7:0];
                        end
                        if (config_enable && config_byte == 3'd2) begin
                            start_latch[11:8] <= config_value[3:0];
                        end
                    end
                    LOOKUP: begin
                        if (rd_data[19:12] != 8'd0) begin
                            synapse_vld  <= 1'b1;
                            synapse_addr <= SYN_AW'(rd_data[11:0]);
                            remaining    <= rd_data[19:12];
                        end
                    end
                    EMIT: begin
                        if (beat) begin
                            synapse_addr <= synapse_addr + SYN_AW'(1);
                            remaining    <= remaining - 8'd1;
                            if (remaining == 8'd1) begin
                                synapse_vld <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
